// File: rtl/cpu_run_step_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_step_ctrl
//   Generates the CPU reset and CPU clock-enable for the SoC top. In run mode
//   the CPU clock is enabled every cycle. In single-step mode it is held off
//   and each press of the step button releases a burst of STEP_CYCLES enabled
//   cycles. A soft-reset button re-enters the reset hold sequence.
//
// Ports
//   clkout      in   system clock
//   ext_reset   in   asynchronous active-low board reset
//   btn_mode_n  in   raw mode button, active-low; toggles run/step
//   btn_step_n  in   raw step button, active-low
//   btn_rst_n   in   raw soft-reset button, active-low
//   cpu_rst_n   out  CPU/SoC reset, active-low, flop output
//   cpu_clk_en  out  CPU clock enable, flop output
//   step_mode   out  1 = single-step mode
//   step_count  out  number of completed step bursts, wraps
//   state_dbg   out  FSM state: HOLD=0, RUN=1, STEP_IDLE=2, STEP_BURST=3
// -----------------------------------------------------------------------------
module cpu_run_step_ctrl #(
    parameter int RST_HOLD_CYCLES = 16,
    parameter int DEBOUNCE_CYCLES = 255,
    parameter int STEP_CYCLES     = 1,
    parameter int CNT_W           = 16
) (
    input  logic             clkout,
    input  logic             ext_reset,
    input  logic             btn_mode_n,
    input  logic             btn_step_n,
    input  logic             btn_rst_n,
    output logic             cpu_rst_n,
    output logic             cpu_clk_en,
    output logic             step_mode,
    output logic [CNT_W-1:0] step_count,
    output logic [1:0]       state_dbg
);

    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W  = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam int BURST_W = $clog2(STEP_CYCLES + 1);

    localparam logic [DB_W-1:0]    DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [BURST_W-1:0] BURST_LEN = BURST_W'(STEP_CYCLES);

    // Button slots in the conditioning arrays.
    localparam int B_MODE = 0;
    localparam int B_STEP = 1;
    localparam int B_RST  = 2;

    typedef enum logic [1:0] {
        ST_HOLD       = 2'd0,
        ST_RUN        = 2'd1,
        ST_STEP_IDLE  = 2'd2,
        ST_STEP_BURST = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Reset synchronizer: assertion is immediate, release is delayed by
    // two clkout edges so every downstream flop leaves reset together.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_sync;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_sync   = rst_sync_q[1];

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the values from before the clock edge.
    always_ff @(posedge clkout or negedge ext_reset) begin
        if (!ext_reset) rst_sync_q <= '0;
        else            rst_sync_q <= rst_sync_d;
    end

    // ------------------------------------------------------------------
    // Button conditioning: 2-flop sync, invert, debounce, press pulse.
    // ------------------------------------------------------------------
    logic [2:0]            btn_raw_n;
    logic [2:0]            btn_meta_q, btn_meta_d;
    logic [2:0]            btn_sync_q, btn_sync_d;
    logic [2:0]            btn_act;
    logic [2:0]            db_lvl_q, db_lvl_d;
    logic [2:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [2:0]            press_q, press_d;

    assign btn_raw_n = {btn_rst_n, btn_step_n, btn_mode_n};
    assign btn_act   = ~btn_sync_q;

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        btn_meta_d = btn_raw_n;
        btn_sync_d = btn_meta_q;
        db_lvl_d   = db_lvl_q;
        press_d    = '0;
        db_cnt_d   = '0;
        for (int i = 0; i < 3; i++) begin
            if (btn_act[i] != db_lvl_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_lvl_d[i] = btn_act[i];
                    // Only a released->pressed flip is a press.
                    press_d[i]  = btn_act[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Run/step FSM
    // ------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic                 step_mode_q, step_mode_d;
    logic [CNT_W-1:0]     step_count_q, step_count_d;
    logic                 cpu_rst_n_q, cpu_rst_n_d;
    logic                 cpu_clk_en_q, cpu_clk_en_d;

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        burst_cnt_d  = burst_cnt_q;
        step_mode_d  = step_mode_q;
        step_count_d = step_count_q;

        if (press_q[B_RST]) begin
            // Soft reset outranks any other press in the same cycle.
            state_d      = ST_HOLD;
            hold_cnt_d   = '0;
            step_count_d = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        hold_cnt_d = '0;
                        state_d    = step_mode_q ? ST_STEP_IDLE : ST_RUN;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (press_q[B_MODE]) begin
                        state_d     = ST_STEP_IDLE;
                        step_mode_d = 1'b1;
                    end
                end
                ST_STEP_IDLE: begin
                    // Mode is tested first so a simultaneous step is dropped.
                    if (press_q[B_MODE]) begin
                        state_d     = ST_RUN;
                        step_mode_d = 1'b0;
                    end else if (press_q[B_STEP]) begin
                        state_d     = ST_STEP_BURST;
                        burst_cnt_d = BURST_LEN;
                    end
                end
                ST_STEP_BURST: begin
                    if (burst_cnt_q == BURST_W'(1)) begin
                        state_d      = ST_STEP_IDLE;
                        step_count_d = step_count_q + 1'b1;
                    end else begin
                        burst_cnt_d = burst_cnt_q - 1'b1;
                    end
                end
                default: state_d = ST_HOLD;
            endcase
        end

        // Outputs are decoded from the next state and registered, so they
        // change on the same edge as state_dbg and never glitch.
        cpu_rst_n_d  = (state_d != ST_HOLD);
        cpu_clk_en_d = (state_d != ST_STEP_IDLE);
    end

    // NOTE: rst_sync resets the logic asynchronously; no memory arrays live
    // here, so every flop has a defined reset value.
    always_ff @(posedge clkout or negedge rst_sync) begin
        if (!rst_sync) begin
            btn_meta_q   <= '1;
            btn_sync_q   <= '1;
            db_lvl_q     <= '0;
            db_cnt_q     <= '0;
            press_q      <= '0;
            state_q      <= ST_HOLD;
            hold_cnt_q   <= '0;
            burst_cnt_q  <= '0;
            step_mode_q  <= 1'b0;
            step_count_q <= '0;
            cpu_rst_n_q  <= 1'b0;
            cpu_clk_en_q <= 1'b0;
        end else begin
            btn_meta_q   <= btn_meta_d;
            btn_sync_q   <= btn_sync_d;
            db_lvl_q     <= db_lvl_d;
            db_cnt_q     <= db_cnt_d;
            press_q      <= press_d;
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            step_mode_q  <= step_mode_d;
            step_count_q <= step_count_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
            cpu_clk_en_q <= cpu_clk_en_d;
        end
    end

    assign cpu_rst_n  = cpu_rst_n_q;
    assign cpu_clk_en = cpu_clk_en_q;
    assign step_mode  = step_mode_q;
    assign step_count = step_count_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_cpu_run_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_run_step_ctrl
//   Directed bench for cpu_run_step_ctrl. Instance u_dut uses the default
//   debounce/hold timing with 3-cycle step bursts; instance u_wrap uses short
//   timing and a 2-bit step counter so the counter wrap is reached quickly.
//   Timing reference: a button level driven just after edge 0 gives a press
//   pulse after edge DEBOUNCE_CYCLES+2 and the FSM reacts on the next edge.
// -----------------------------------------------------------------------------
module tb_cpu_run_step_ctrl;

    localparam int DB = 255;

    logic        clkout = 1'b0;
    logic        ext_reset = 1'b0;
    logic        a_mode_n = 1'b1, a_step_n = 1'b1, a_rst_n = 1'b1;
    logic        b_mode_n = 1'b1, b_step_n = 1'b1, b_rst_n = 1'b1;

    logic        a_cpu_rst_n, a_cpu_clk_en, a_step_mode;
    logic [15:0] a_step_count;
    logic [1:0]  a_state;

    logic        b_cpu_rst_n, b_cpu_clk_en, b_step_mode;
    logic [1:0]  b_step_count;
    logic [1:0]  b_state;

    int checks = 0;
    int errors = 0;

    always #5 clkout = ~clkout;

    cpu_run_step_ctrl #(
        .RST_HOLD_CYCLES(16), .DEBOUNCE_CYCLES(DB), .STEP_CYCLES(3), .CNT_W(16)
    ) u_dut (
        .clkout(clkout), .ext_reset(ext_reset),
        .btn_mode_n(a_mode_n), .btn_step_n(a_step_n), .btn_rst_n(a_rst_n),
        .cpu_rst_n(a_cpu_rst_n), .cpu_clk_en(a_cpu_clk_en), .step_mode(a_step_mode),
        .step_count(a_step_count), .state_dbg(a_state)
    );

    cpu_run_step_ctrl #(
        .RST_HOLD_CYCLES(4), .DEBOUNCE_CYCLES(4), .STEP_CYCLES(1), .CNT_W(2)
    ) u_wrap (
        .clkout(clkout), .ext_reset(ext_reset),
        .btn_mode_n(b_mode_n), .btn_step_n(b_step_n), .btn_rst_n(b_rst_n),
        .cpu_rst_n(b_cpu_rst_n), .cpu_clk_en(b_cpu_clk_en), .step_mode(b_step_mode),
        .step_count(b_step_count), .state_dbg(b_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clkout);
        #1;
    endtask

    task automatic set_btn(input int sel, input logic v);
        case (sel)
            0: a_mode_n = v;
            1: a_step_n = v;
            2: a_rst_n  = v;
            3: b_mode_n = v;
            4: b_step_n = v;
            default: ;
        endcase
    endtask

    // Full press: hold low, release, wait for the release to debounce.
    task automatic press(input int sel, input int low_n, input int high_n);
        set_btn(sel, 1'b0);
        tick(low_n);
        set_btn(sel, 1'b1);
        tick(high_n);
    endtask

    initial begin
        int en_cycles;

        // ---------------- reset values ----------------
        tick(3);
        check("rst_cpu_rst_n", 32'(a_cpu_rst_n), 0);
        check("rst_clk_en",    32'(a_cpu_clk_en), 0);
        check("rst_step_mode", 32'(a_step_mode), 0);
        check("rst_count",     32'(a_step_count), 0);
        check("rst_state",     32'(a_state), 0);

        // ---------------- 1: hold sequence ----------------
        ext_reset = 1'b1;
        tick(17);
        check("hold_state",    32'(a_state), 0);
        check("hold_rst_n",    32'(a_cpu_rst_n), 0);
        check("hold_clk_en",   32'(a_cpu_clk_en), 1);
        tick(1);
        check("run_state",     32'(a_state), 1);
        check("run_rst_n",     32'(a_cpu_rst_n), 1);
        check("run_clk_en",    32'(a_cpu_clk_en), 1);

        // Step press in RUN is ignored.
        press(1, 300, 270);
        check("run_step_state", 32'(a_state), 1);
        check("run_step_count", 32'(a_step_count), 0);
        check("run_step_en",    32'(a_cpu_clk_en), 1);

        // ---------------- 2: mode press to step mode ----------------
        a_mode_n = 1'b0;
        tick(DB + 2);
        check("mode_pre_state", 32'(a_state), 1);
        check("mode_pre_en",    32'(a_cpu_clk_en), 1);
        tick(1);
        check("mode_state",     32'(a_state), 2);
        check("mode_en",        32'(a_cpu_clk_en), 0);
        check("mode_step_mode", 32'(a_step_mode), 1);
        tick(300 - (DB + 3));
        a_mode_n = 1'b1;
        tick(270);
        check("mode_rel_state", 32'(a_state), 2);

        // ---------------- 3: 3-cycle step burst ----------------
        a_step_n = 1'b0;
        tick(DB + 3);
        check("burst1_state", 32'(a_state), 3);
        check("burst1_en",    32'(a_cpu_clk_en), 1);
        tick(2);
        check("burst3_state", 32'(a_state), 3);
        check("burst3_en",    32'(a_cpu_clk_en), 1);
        check("burst3_count", 32'(a_step_count), 0);
        tick(1);
        check("burst_end_state", 32'(a_state), 2);
        check("burst_end_en",    32'(a_cpu_clk_en), 0);
        check("burst_end_count", 32'(a_step_count), 1);
        tick(39);
        a_step_n = 1'b1;
        tick(270);

        // ---------------- 4: short glitch gives no step ----------------
        a_step_n = 1'b0;
        tick(100);
        a_step_n = 1'b1;
        en_cycles = 0;
        for (int i = 0; i < 400; i++) begin
            tick(1);
            if (a_cpu_clk_en) en_cycles++;
        end
        check("glitch_en_cycles", 32'(en_cycles), 0);
        check("glitch_count",     32'(a_step_count), 1);
        check("glitch_state",     32'(a_state), 2);

        // ---------------- simultaneous mode+step: mode wins ----------------
        a_mode_n = 1'b0;
        a_step_n = 1'b0;
        tick(300);
        a_mode_n = 1'b1;
        a_step_n = 1'b1;
        tick(270);
        check("both_state",     32'(a_state), 1);
        check("both_step_mode", 32'(a_step_mode), 0);
        check("both_count",     32'(a_step_count), 1);
        check("both_en",        32'(a_cpu_clk_en), 1);

        // ---------------- soft reset in step mode ----------------
        press(0, 300, 270);
        check("restep_state", 32'(a_state), 2);
        a_rst_n = 1'b0;
        tick(DB + 3);
        check("soft_state",     32'(a_state), 0);
        check("soft_rst_n",     32'(a_cpu_rst_n), 0);
        check("soft_step_mode", 32'(a_step_mode), 1);
        check("soft_count",     32'(a_step_count), 0);
        tick(300 - (DB + 3));
        a_rst_n = 1'b1;
        tick(270);
        check("soft_end_state", 32'(a_state), 2);
        check("soft_end_rst_n", 32'(a_cpu_rst_n), 1);
        check("soft_end_en",    32'(a_cpu_clk_en), 0);

        // ---------------- 6: ext_reset in second burst cycle ----------------
        a_step_n = 1'b0;
        tick(DB + 4);
        check("abort_pre_state", 32'(a_state), 3);
        check("abort_pre_en",    32'(a_cpu_clk_en), 1);
        ext_reset = 1'b0;
        #1;
        check("abort_rst_n",     32'(a_cpu_rst_n), 0);
        check("abort_en",        32'(a_cpu_clk_en), 0);
        check("abort_step_mode", 32'(a_step_mode), 0);
        check("abort_count",     32'(a_step_count), 0);
        check("abort_state",     32'(a_state), 0);
        a_step_n = 1'b1;
        tick(2);
        ext_reset = 1'b1;
        tick(18);
        check("rerun_state", 32'(a_state), 1);
        check("rerun_rst_n", 32'(a_cpu_rst_n), 1);
        check("rerun_count", 32'(a_step_count), 0);

        // ---------------- 5: step_count wrap (2-bit instance) ----------------
        check("wrap_run_state", 32'(b_state), 1);
        press(3, 10, 10);
        check("wrap_step_state", 32'(b_state), 2);
        for (int i = 0; i < 3; i++) press(4, 10, 10);
        check("wrap_count_max", 32'(b_step_count), 3);
        press(4, 10, 10);
        check("wrap_count_zero", 32'(b_step_count), 0);
        check("wrap_state",      32'(b_state), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
